ssd_scan_decoder: RTL
=====================

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 Parameter DIGITS, default 8; number of anode lines observed.
REQ-002 Parameter STABLE, default 4; consecutive identical synchronized samples required before capture (legal range 2..15).
REQ-003 Parameter ENABLE_MASK, default 8'b0000_0011; digits that must be captured to complete a frame.
REQ-004 ssd_scan_decoder_port_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 ssd_scan_decoder_port_rst  input  1  asynchronous, active-low reset.
REQ-006 ssd_scan_decoder_port_ssd  input  7  active-low segments; bit0=a … bit6=g.
REQ-007 ssd_scan_decoder_port_an  input  DIGITS  active-low anodes; bit i selects digit i.
REQ-008 ssd_scan_decoder_port_digits  output  4*DIGITS  decoded hex values; nibble i = digit i; updated only at frame completion.
REQ-009 ssd_scan_decoder_port_frame_done  output  1  one-cycle pulse when port_digits updates.
REQ-010 ssd_scan_decoder_port_err  output  1  sticky error flag.

Function
REQ-011 port_ssd and port_an SHALL each pass through a 2-flop synchronizer; all later logic uses the synchronized sample S = {an_s, ssd_s}.
REQ-012 Stability counter: cleared when S differs from the previous S; otherwise increments, saturating at STABLE-1.
REQ-013 FSM states: IDLE, SETTLE, HOLD.
REQ-014 IDLE: an_s all ones (no anode selected); no capture. Any change to S with ≥1 anode low -> SETTLE.
REQ-015 SETTLE: when the counter reaches STABLE-1, evaluate S once and go to HOLD; any change to S before that restarts the count in SETTLE.
REQ-016 HOLD: no further evaluation; any change to S -> SETTLE (or IDLE if an_s all ones).
REQ-017 Evaluation, exactly one anode i low and ssd pattern legal: shadow[i] <= decoded hex; seen[i] <= 1.
REQ-018 Legal patterns (active-high gfedcba, after inverting ssd_s): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 Evaluation with ≥2 anodes low, or an illegal segment pattern (including blank): port_err <= 1; shadow and seen unchanged.
REQ-020 When (seen & ENABLE_MASK) == ENABLE_MASK on a cycle: port_digits <= shadow for all digits, port_frame_done = 1 for the following cycle, seen <= 0 in the same edge.
REQ-021 Capture and frame completion on the same edge: the newly captured value SHALL be included in the copied frame.
REQ-022 A digit captured twice before frame completion: latest value wins.
REQ-023 Digits outside ENABLE_MASK are still decoded into shadow and copied at frame completion but do not gate it.
REQ-024 Capture latency: 2 (sync) + STABLE cycles after input change; frame_done one cycle after the completing capture.
REQ-025 port_err is cleared only by reset.

Reset
REQ-026 On port_rst low (asynchronous): synchronizers all ones, counter 0, FSM IDLE, shadow 0, seen 0, port_digits 0, port_frame_done 0, port_err 0.
REQ-027 Reset mid-frame discards partial captures; first frame after reset requires fresh captures of all ENABLE_MASK digits.

Structure
REQ-028 Shared package ssd_pkg: the 16 segment pattern constants, segment bit-order constants, FSM state encodings.
REQ-029 One sub-module ssd_seg2hex: combinational 7-bit pattern -> {legal, 4-bit hex}; all sequential logic stays in ssd_scan_decoder.

Verification
REQ-030 Scan an=FE/ssd=~06 then an=FD/ssd=~5B, each held 20 cycles -> frame_done once; digits[7:0]=8'h21; err=0.
REQ-031 Glitch: hold an=FE, ssd toggles every 2 cycles (STABLE=4) -> no capture, no frame_done.
REQ-032 an=FC (two anodes) held 10 cycles -> err=1 and stays 1 through subsequent legal frames.
REQ-033 Illegal ssd=~7'h01 on digit 0 -> err=1; digit 0 not marked seen; frame_done only after a later legal 0 capture.
REQ-034 Reset asserted after digit 0 captured -> all outputs 0 asynchronously; after release, digit 1 alone -> no frame_done.
REQ-035 Digit 0 captured as 3 then 7 before digit 1=A -> digits[7:0]=8'hA7.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants for the seven-segment scan decoder:
//               segment bit order, legal hex glyphs and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Segment bit positions within an active-high gfedcba pattern
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G + 1;

    // Active-high glyphs for hex digits 0..F
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

    // Scan-tracking FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } ssd_state_t;

endpackage
`default_nettype wire

// File: rtl/ssd_seg2hex.sv
`default_nettype none
// ============================================================================
// Module      : ssd_seg2hex
// Description : Combinational decode of an active-high gfedcba segment
//               pattern into a hex nibble plus a legal-glyph flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_seg2hex
    import ssd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_hex
);

    // Match against the sixteen legal glyphs; anything else (blank too) is illegal
    always_comb begin
        o_legal = 1'b1;
        o_hex   = 4'h0;
        case (i_seg)
            SEG_HEX_0: o_hex = 4'h0;
            SEG_HEX_1: o_hex = 4'h1;
            SEG_HEX_2: o_hex = 4'h2;
            SEG_HEX_3: o_hex = 4'h3;
            SEG_HEX_4: o_hex = 4'h4;
            SEG_HEX_5: o_hex = 4'h5;
            SEG_HEX_6: o_hex = 4'h6;
            SEG_HEX_7: o_hex = 4'h7;
            SEG_HEX_8: o_hex = 4'h8;
            SEG_HEX_9: o_hex = 4'h9;
            SEG_HEX_A: o_hex = 4'hA;
            SEG_HEX_B: o_hex = 4'hB;
            SEG_HEX_C: o_hex = 4'hC;
            SEG_HEX_D: o_hex = 4'hD;
            SEG_HEX_E: o_hex = 4'hE;
            SEG_HEX_F: o_hex = 4'hF;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_decoder
// Description : Observes a multiplexed seven-segment display bus, waits for
//               each digit to settle, decodes it and publishes a full frame
//               once every enabled digit has been captured.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int                DIGITS      = 8,
    parameter int                STABLE      = 4,
    parameter logic [DIGITS-1:0] ENABLE_MASK = DIGITS'(8'b0000_0011)
) (
    input  logic                  ssd_scan_decoder_port_clk,
    input  logic                  ssd_scan_decoder_port_rst,
    input  logic [6:0]            ssd_scan_decoder_port_ssd,
    input  logic [DIGITS-1:0]     ssd_scan_decoder_port_an,
    output logic [4*DIGITS-1:0]   ssd_scan_decoder_port_digits,
    output logic                  ssd_scan_decoder_port_frame_done,
    output logic                  ssd_scan_decoder_port_err
);

    localparam logic [3:0] c_CNT_MAX = 4'(STABLE - 1);

    logic [6:0]          r_ssd_meta, r_ssd_sync;
    logic [DIGITS-1:0]   r_an_meta, r_an_sync;
    logic [DIGITS+6:0]   w_s, r_s_prev;
    logic [3:0]          r_cnt;
    ssd_state_t          r_state, w_state_nxt;
    logic                w_eval;
    logic                w_change, w_an_none, w_one_hot;
    logic [DIGITS-1:0]   w_an_act;
    logic                w_legal;
    logic [3:0]          w_hex;
    logic                w_capture, w_frame;
    logic [4*DIGITS-1:0] r_shadow, w_shadow_nxt, r_digits;
    logic [DIGITS-1:0]   r_seen, w_seen_nxt;
    logic                r_frame_done, r_err;

    // Two-flop synchronizers; idle bus (all high) is the reset value
    always_ff @(posedge ssd_scan_decoder_port_clk or negedge ssd_scan_decoder_port_rst) begin
        if (!ssd_scan_decoder_port_rst) begin
            r_ssd_meta <= '1;
            r_ssd_sync <= '1;
            r_an_meta  <= '1;
            r_an_sync  <= '1;
        end else begin
            r_ssd_meta <= ssd_scan_decoder_port_ssd;
            r_ssd_sync <= r_ssd_meta;
            r_an_meta  <= ssd_scan_decoder_port_an;
            r_an_sync  <= r_an_meta;
        end
    end

    assign w_s       = {r_an_sync, r_ssd_sync};
    assign w_change  = (w_s != r_s_prev);
    assign w_an_none = &r_an_sync;
    assign w_an_act  = ~r_an_sync;
    assign w_one_hot = (w_an_act != '0) && ((w_an_act & (w_an_act - DIGITS'(1))) == '0);

    ssd_seg2hex u_seg2hex (
        .i_seg   (~r_ssd_sync),
        .o_legal (w_legal),
        .o_hex   (w_hex)
    );

    // Stability counter: restarts on any change of the sample, saturates at the threshold
    always_ff @(posedge ssd_scan_decoder_port_clk or negedge ssd_scan_decoder_port_rst) begin
        if (!ssd_scan_decoder_port_rst) begin
            r_s_prev <= '1;
            r_cnt    <= 4'd0;
        end else begin
            r_s_prev <= w_s;
            if (w_change)
                r_cnt <= 4'd0;
            else if (r_cnt != c_CNT_MAX)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    // FSM state register
    always_ff @(posedge ssd_scan_decoder_port_clk or negedge ssd_scan_decoder_port_rst) begin
        if (!ssd_scan_decoder_port_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state; a single evaluation strobe fires when a settled sample is reached
    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_change && !w_an_none)
                    w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_change) begin
                    w_state_nxt = w_an_none ? ST_IDLE : ST_SETTLE;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_eval      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_change)
                    w_state_nxt = w_an_none ? ST_IDLE : ST_SETTLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_capture = w_eval && w_one_hot && w_legal;

    // Post-capture view of shadow/seen, so a completing capture lands in the same frame
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_seen_nxt   = r_seen;
        if (w_capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_an_act[i]) begin
                    w_shadow_nxt[4*i +: 4] = w_hex;
                    w_seen_nxt[i]          = 1'b1;
                end
            end
        end
    end

    assign w_frame = ((w_seen_nxt & ENABLE_MASK) == ENABLE_MASK);

    // Capture storage, frame publication and sticky error
    always_ff @(posedge ssd_scan_decoder_port_clk or negedge ssd_scan_decoder_port_rst) begin
        if (!ssd_scan_decoder_port_rst) begin
            r_shadow     <= '0;
            r_seen       <= '0;
            r_digits     <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_shadow     <= w_shadow_nxt;
            r_seen       <= w_frame ? '0 : w_seen_nxt;
            r_frame_done <= w_frame;
            if (w_frame)
                r_digits <= w_shadow_nxt;
            if (w_eval && !(w_one_hot && w_legal))
                r_err <= 1'b1;
        end
    end

    assign ssd_scan_decoder_port_digits     = r_digits;
    assign ssd_scan_decoder_port_frame_done = r_frame_done;
    assign ssd_scan_decoder_port_err        = r_err;

endmodule
`default_nettype wire
